// File: rtl/rip_axi_arbiter_pkg.sv
// Shared types and helpers for the rip_axi_master request arbiter.
package rip_axi_arbiter_const;

    localparam int B_WIDTH   = 8;
    localparam int MAX_PORTS = 8;
    localparam int IDX_W     = 3;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;

    // Search upward from ptr+1, wrapping; unused upper bits are zero so the
    // 8-wide wrap is equivalent to wrapping at NUM_PORTS.
    function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                     input logic [IDX_W-1:0]     ptr);
        logic [MAX_PORTS-1:0] oh;
        logic [IDX_W-1:0]     idx;
        oh = '0;
        for (int i = 1; i <= MAX_PORTS; i++) begin
            idx = ptr + IDX_W'(i);
            if (req[idx] && oh == '0) oh[idx] = 1'b1;
        end
        return oh;
    endfunction

    function automatic int line_shift(input int line_w);
        return $clog2(line_w / B_WIDTH);
    endfunction

endpackage

// File: rtl/rip_rr_arbiter.sv
// One channel of the arbiter: round-robin pick, IDLE/WAIT FSM and grant register.
module rip_rr_arbiter
    import rip_axi_arbiter_const::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 ready,
    input  logic                 done,
    output logic                 issue,
    output logic [IDX_W-1:0]     win,
    output logic                 busy,
    output logic                 valid,
    output logic [NUM_PORTS-1:0] ack,
    output logic [NUM_PORTS-1:0] fin
);

    arb_state_e           state, state_nxt;
    logic [IDX_W-1:0]     ptr, grant;
    logic [MAX_PORTS-1:0] pick;

    assign pick = rr_pick(MAX_PORTS'(req), ptr);
    assign busy = (state == ARB_WAIT);

    always_comb begin
        win = '0;
        for (int i = 0; i < MAX_PORTS; i++)
            if (pick[i]) win = IDX_W'(i);
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ARB_IDLE: if (|req && ready) begin
                issue     = 1'b1;
                state_nxt = ARB_WAIT;
            end
            ARB_WAIT: if (done) state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= IDX_W'(NUM_PORTS - 1);
            grant <= '0;
            valid <= 1'b0;
            ack   <= '0;
            fin   <= '0;
        end else begin
            valid <= issue;
            ack   <= '0;
            fin   <= '0;
            if (issue) begin
                ptr   <= win;
                grant <= win;
                ack   <= NUM_PORTS'(pick);
            end
            if (busy && done) fin <= NUM_PORTS'(1) << grant;
        end
    end

endmodule

// File: rtl/rip_axi_arbiter.sv
// Shares one rip_axi_master request interface between NUM_PORTS requesters.
// Define RIP_AXI_ARB_RAW_HAZARD_EN to hold reads behind an in-flight write to the same line.
module rip_axi_arbiter
    import rip_axi_arbiter_const::*;
#(
    parameter  int NUM_PORTS  = 2,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int BURST_LEN  = 2,
    localparam int LINE_W     = DATA_WIDTH * BURST_LEN,
    localparam int STRB_W     = LINE_W / B_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_wvalid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_waddr,
    input  logic [NUM_PORTS*LINE_W-1:0]     req_wdata,
    input  logic [NUM_PORTS*STRB_W-1:0]     req_wstrb,
    output logic [NUM_PORTS-1:0]            req_wack,
    output logic [NUM_PORTS-1:0]            req_wdone,
    input  logic [NUM_PORTS-1:0]            req_rvalid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_raddr,
    output logic [NUM_PORTS-1:0]            req_rack,
    output logic [NUM_PORTS-1:0]            req_rdone,
    output logic [LINE_W-1:0]               req_rdata,
    input  logic                            m_wready,
    output logic [ADDR_WIDTH-1:0]           m_waddr,
    output logic [LINE_W-1:0]               m_wdata,
    output logic [STRB_W-1:0]               m_wstrb,
    output logic                            m_wvalid,
    input  logic                            m_wdone,
    input  logic                            m_rready,
    output logic [ADDR_WIDTH-1:0]           m_raddr,
    output logic                            m_rvalid,
    input  logic [LINE_W-1:0]               m_rdata,
    input  logic                            m_rdone
);

    logic                  w_issue, r_issue, w_busy, r_busy;
    logic [IDX_W-1:0]      w_win, r_win;
    logic [NUM_PORTS-1:0]  r_req;
    logic [ADDR_WIDTH-1:0] w_win_addr, r_win_addr;

    assign w_win_addr = req_waddr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign r_win_addr = req_raddr[int'(r_win)*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef RIP_AXI_ARB_RAW_HAZARD_EN
    localparam int LSH = line_shift(LINE_W);
    logic [ADDR_WIDTH-1:0] w_line_addr;

    // The write being issued this cycle is not yet in m_waddr.
    assign w_line_addr = w_issue ? w_win_addr : m_waddr;

    always_comb begin
        r_req = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            r_req[p] = req_rvalid[p] &&
                       !((w_busy || w_issue) &&
                         ((req_raddr[p*ADDR_WIDTH +: ADDR_WIDTH] >> LSH) == (w_line_addr >> LSH)));
    end
`else
    logic unused_w_busy;
    assign unused_w_busy = w_busy;
    assign r_req         = req_rvalid;
`endif

    rip_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_wr_arb (
        .clk(clk), .rst(rst), .req(req_wvalid), .ready(m_wready), .done(m_wdone),
        .issue(w_issue), .win(w_win), .busy(w_busy),
        .valid(m_wvalid), .ack(req_wack), .fin(req_wdone)
    );

    rip_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rd_arb (
        .clk(clk), .rst(rst), .req(r_req), .ready(m_rready), .done(m_rdone),
        .issue(r_issue), .win(r_win), .busy(r_busy),
        .valid(m_rvalid), .ack(req_rack), .fin(req_rdone)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_waddr   <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_raddr   <= '0;
            req_rdata <= '0;
        end else begin
            if (w_issue) begin
                m_waddr <= w_win_addr;
                m_wdata <= req_wdata[int'(w_win)*LINE_W +: LINE_W];
                m_wstrb <= req_wstrb[int'(w_win)*STRB_W +: STRB_W];
            end
            if (r_issue)           m_raddr   <= r_win_addr;
            if (r_busy && m_rdone) req_rdata <= m_rdata;
        end
    end

endmodule

// File: doc/rip_axi_arbiter.md
Name: rip_axi_arbiter

Overview:
- Shares one rip_axi_master user-side request interface between NUM_PORTS requesters, e.g. instruction fetch, data load/store and DMA.
- Write and read channels are arbitrated independently, each round-robin, so one write and one read can be in flight at the same time.
- Sits between the core memory ports and rip_axi_master. Registers the granted payload and routes done/rdata back to the winner.

Parameters:
- NUM_PORTS, 2, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, AXI beat width.
- BURST_LEN, 2, beats per transfer. LINE_W = DATA_WIDTH*BURST_LEN; STRB_W = LINE_W/B_WIDTH (B_WIDTH from rip_const).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_wvalid  in  NUM_PORTS  per-port write request (level, held until ack)
- req_waddr  in  NUM_PORTS*ADDR_WIDTH  packed write addresses
- req_wdata  in  NUM_PORTS*LINE_W  packed write data
- req_wstrb  in  NUM_PORTS*STRB_W  packed write strobes
- req_wack  out  NUM_PORTS  one-hot pulse: request accepted
- req_wdone  out  NUM_PORTS  one-hot pulse: write completed
- req_rvalid  in  NUM_PORTS  per-port read request (level, held until ack)
- req_raddr  in  NUM_PORTS*ADDR_WIDTH  packed read addresses
- req_rack  out  NUM_PORTS  one-hot pulse: read accepted
- req_rdone  out  NUM_PORTS  one-hot pulse: rdata valid for that port
- req_rdata  out  LINE_W  read data, valid while req_rdone set
- m_wready  in  1  master write idle
- m_waddr  out  ADDR_WIDTH  to master
- m_wdata  out  LINE_W  to master
- m_wstrb  out  STRB_W  to master
- m_wvalid  out  1  single-cycle issue pulse
- m_wdone  in  1  master write complete
- m_rready  in  1  master read idle
- m_raddr  out  ADDR_WIDTH  to master
- m_rvalid  out  1  single-cycle issue pulse
- m_rdata  in  LINE_W  master read data
- m_rdone  in  1  master read complete

Behaviour:
- Reset: every output is 0. Both FSMs are IDLE. Both round-robin pointers are NUM_PORTS-1, so port 0 has first priority.
- Reset is async; all state is cleared immediately, including mid-transfer. The integrator drives rip_axi_master rstn = ~rst so that no done pulse is orphaned.
- Per-channel FSM (write shown; read is identical) has states IDLE and WAIT.
- IDLE → WAIT when any req_wvalid is set and m_wready=1. At that clock edge:
  - winner = first set bit searching upward from ptr+1, wrapping;
  - register the winner's addr/data/strb onto m_w*;
  - m_wvalid<=1 for exactly one cycle; req_wack[winner]<=1 for one cycle;
  - grant<=winner; ptr<=winner.
- Latency: request seen at edge N → m_wvalid and ack high in cycle N+1.
- Requester may change its payload or drop valid after seeing ack.
- In IDLE with m_wready=0: no issue; requests wait.
- WAIT: m_wvalid=0, and new requests are not accepted.
  - On m_wdone=1: req_wdone[grant]<=1 for one cycle, state<=IDLE.
  - The earliest re-issue is the cycle after done is seen, gated by m_wready.
- Read channel: on m_rdone, req_rdata<=m_rdata and req_rdone[grant]<=1 in the same registered cycle. req_rdata holds its value until the next rdone.
- Both channels may issue in the same cycle, for the same or different ports.
- A port may have one write and one read outstanding at once.
- m_w*/m_raddr payload registers keep their last value while idle.
- Spurious m_wdone/m_rdone in IDLE is ignored.
- Round-robin guarantee: with all ports continuously requesting, grants rotate 0,1,…,NUM_PORTS-1,0. No port waits more than NUM_PORTS-1 transfers.

Optional Feature:
- RIP_AXI_ARB_RAW_HAZARD_EN defined:
  - A read candidate is masked from arbitration while the write FSM is in WAIT (or issuing this cycle) and the read address matches the write address at line granularity (addr >> log2(LINE_W/8)).
  - Blocked ports are skipped; other read ports may still win.
  - Guarantees read-after-write ordering to the same line.
- Undefined: read and write channels are fully independent.

Decomposition:
- rip_axi_arbiter_const package holds:
  - typedef arb_state_e {ARB_IDLE, ARB_WAIT};
  - function rr_pick(req, ptr), returning a one-hot winner;
  - line-index localparam helper.
- Sub-module rip_rr_arbiter: round-robin pointer, pick and grant register, parameterised by NUM_PORTS. Instantiated twice, once for write and once for read.

Test Plan:
- Port0 write 0x10, data 0x1234, strb '1, m_wready=1 → m_wvalid and req_wack[0] one cycle later with m_waddr=0x10; after m_wdone, req_wdone[0] pulses once.
- Ports 0 and 1 both hold write requests for three transfers (0x20, 0x28) → grant order 0,1,0; acks one-hot and never overlapping.
- Port0 write 0x30 and port1 read 0x38 in the same cycle → m_wvalid and m_rvalid both pulse next cycle; port1 read of 0x38 returns rdata (e.g. 0xfab1e55) with req_rdone[1] only.
- m_wready=0 with port1 requesting → no m_wvalid; raise m_wready → issue next cycle.
- With the macro: write 0x20 in WAIT, read 0x24 (same 8-byte line) → m_rvalid is withheld until the cycle after m_wdone. Without the macro → read issues immediately.
- rst asserted during WAIT → all outputs are 0 asynchronously; after release, a port0 read of 0x10 is granted first.
